// File: rtl/tube_hit_event_buffer.sv
// tube_hit_event_buffer: triggered drift-tube hit capture into a two-word-per-event FIFO, read by RD_EN strobes.
// Define EVENT_TAG_EN to add a per-event tag (TAG_W bits) stored with each word and shown on EVT_TAG.
module tube_hit_event_buffer #(
  parameter int N_TUBES = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int WINDOW_CYCLES = 50,
  parameter int HOLDOFF_CYCLES = 10,
  parameter int SYNC_STAGES = 2,
  parameter int DROP_W = 8
`ifdef EVENT_TAG_EN
  , parameter int TAG_W = 4
`endif
) (
  input  logic CLK,
  input  logic RST,
  input  logic SCIN_COIN,
  input  logic [N_TUBES-1:0] TUBE3A,
  input  logic [N_TUBES-1:0] TUBE3B,
  input  logic [N_TUBES-1:0] TUBE4A,
  input  logic [N_TUBES-1:0] TUBE4B,
  input  logic RD_EN,
  output logic [N_TUBES-1:0] OTUBEX,
  output logic [N_TUBES-1:0] OTUBEY,
  output logic RD_LAYER,
  output logic RD_VALID,
  output logic RD_EMPTY,
  output logic BUSY,
`ifdef EVENT_TAG_EN
  output logic [TAG_W-1:0] EVT_TAG,
`endif
  output logic [DROP_W-1:0] DROP_CNT
);
  localparam int N = N_TUBES;
  localparam int SW = 4*N+2;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW+1;
  localparam int MC = WINDOW_CYCLES > HOLDOFF_CYCLES ? WINDOW_CYCLES : HOLDOFF_CYCLES;
  localparam int TW = $clog2(MC+1);
`ifdef EVENT_TAG_EN
  localparam int EW = 2*N+1+TAG_W;
`else
  localparam int EW = 2*N+1;
`endif
  typedef enum logic [2:0] {IDLE, WINDOW, PUSH_A, PUSH_B, HOLDOFF} state_t;
  state_t state, state_n, after;
  logic [SYNC_STAGES-1:0][SW-1:0] sync_q;
  logic [SW-1:0] prev_q, edge_q;
  logic rd_edge, trig, win_last, hold_last, room, push, pop;
  logic [4*N-1:0] tube_edge, bm;
  logic [TW-1:0] cnt;
  logic [CW-1:0] count, count_n;
  logic [AW-1:0] wptr, rptr;
  logic [2*N:0] word;
  logic [EW-1:0] wdata, head;
  logic [EW-1:0] mem [FIFO_DEPTH];
  // edges are registered, so every async input sees SYNC_STAGES+1 cycles of latency
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      sync_q <= '0;
      prev_q <= '0;
      edge_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], {RD_EN, SCIN_COIN, TUBE4B, TUBE4A, TUBE3B, TUBE3A}};
      prev_q <= sync_q[SYNC_STAGES-1];
      edge_q <= sync_q[SYNC_STAGES-1] & ~prev_q;
    end
  assign rd_edge = edge_q[SW-1];
  assign trig = edge_q[SW-2];
  assign tube_edge = edge_q[4*N-1:0];
  assign win_last = cnt == TW'(WINDOW_CYCLES-1);
  assign hold_last = cnt == TW'(HOLDOFF_CYCLES-1);
  assign room = count <= CW'(FIFO_DEPTH-2);
  assign after = HOLDOFF_CYCLES == 0 ? IDLE : HOLDOFF;
  assign BUSY = state != IDLE;
  always_ff @(posedge CLK or posedge RST)
    if (RST) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state;
    case (state)
      IDLE: state_n = trig ? WINDOW : IDLE;
      WINDOW: state_n = !win_last ? WINDOW : room ? PUSH_A : after;
      PUSH_A: state_n = PUSH_B;
      PUSH_B: state_n = after;
      HOLDOFF: state_n = hold_last ? IDLE : HOLDOFF;
      default: state_n = IDLE;
    endcase
  end
`ifdef EVENT_TAG_EN
  logic [TAG_W-1:0] tag;
  assign wdata = {tag, word};
  always_ff @(posedge CLK or posedge RST)
    if (RST) tag <= '0;
    else if (state == PUSH_B) tag <= tag + 1'b1;
`else
  assign wdata = word;
`endif
  // cnt restarts on every state change, so it counts from 0 in WINDOW and HOLDOFF
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      cnt <= '0;
      bm <= '0;
      DROP_CNT <= '0;
    end else begin
      cnt <= state != state_n ? '0 : cnt + 1'b1;
      if (state == IDLE && trig) bm <= '0;
      else if (state == WINDOW) bm <= bm | tube_edge;
      if (state == WINDOW && win_last && !room && DROP_CNT != '1) DROP_CNT <= DROP_CNT + 1'b1;
    end
  assign word = state == PUSH_B ? {bm[2*N-1:N], bm[4*N-1:3*N], 1'b1} : {bm[N-1:0], bm[3*N-1:2*N], 1'b0};
  assign push = state == PUSH_A || state == PUSH_B;
  assign pop = rd_edge && count != '0;
  assign count_n = count + CW'(push) - CW'(pop);
  assign head = mem[rptr];
  always_ff @(posedge CLK)
    if (push) mem[wptr] <= wdata;
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      wptr <= '0;
      rptr <= '0;
      count <= '0;
      RD_EMPTY <= 1'b1;
      RD_VALID <= 1'b0;
      {OTUBEX, OTUBEY, RD_LAYER} <= '0;
`ifdef EVENT_TAG_EN
      EVT_TAG <= '0;
`endif
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop) rptr <= rptr + 1'b1;
      count <= count_n;
      RD_EMPTY <= count_n == '0;
      if (rd_edge) RD_VALID <= pop;
      if (pop) {OTUBEX, OTUBEY, RD_LAYER} <= head[2*N:0];
`ifdef EVENT_TAG_EN
      if (pop) EVT_TAG <= head[EW-1 -: TAG_W];
`endif
    end
endmodule

// File: tb/tb_tube_hit_event_buffer.sv
// tb_tube_hit_event_buffer: directed bench; u1 uses default parameters, u2 a 4-deep FIFO, 8-cycle window, no holdoff and a 2-bit drop counter.
module tb_tube_hit_event_buffer;
  logic clk = 0, rst = 1, scin = 0, scin2 = 0, rd = 0, rd2 = 0;
  logic [7:0] t3a = 0, t3b = 0, t4a = 0, t4b = 0;
  logic [7:0] x, y, x2, y2, drop;
  logic [1:0] drop2;
  logic lay, val, emp, busy, lay2, val2, emp2, busy2;
`ifdef EVENT_TAG_EN
  logic [3:0] tag, tag2;
`endif
  int n_chk = 0, n_fail = 0;
  always #5 clk = ~clk;
  tube_hit_event_buffer u1 (
    .CLK(clk), .RST(rst), .SCIN_COIN(scin), .TUBE3A(t3a), .TUBE3B(t3b), .TUBE4A(t4a), .TUBE4B(t4b),
    .RD_EN(rd), .OTUBEX(x), .OTUBEY(y), .RD_LAYER(lay), .RD_VALID(val), .RD_EMPTY(emp), .BUSY(busy),
`ifdef EVENT_TAG_EN
    .EVT_TAG(tag),
`endif
    .DROP_CNT(drop));
  tube_hit_event_buffer #(.FIFO_DEPTH(4), .WINDOW_CYCLES(8), .HOLDOFF_CYCLES(0), .DROP_W(2)) u2 (
    .CLK(clk), .RST(rst), .SCIN_COIN(scin2), .TUBE3A(t3a), .TUBE3B(t3b), .TUBE4A(t4a), .TUBE4B(t4b),
    .RD_EN(rd2), .OTUBEX(x2), .OTUBEY(y2), .RD_LAYER(lay2), .RD_VALID(val2), .RD_EMPTY(emp2), .BUSY(busy2),
`ifdef EVENT_TAG_EN
    .EVT_TAG(tag2),
`endif
    .DROP_CNT(drop2));

  task automatic start_event();
    int n;
    n = 0;
    @(negedge clk) scin = 1;
    repeat (3) @(negedge clk);
    scin = 0;
    while (!busy && n < 10) begin
      @(negedge clk);
      n++;
    end
    n_chk++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL start_busy got %b want 1", busy);
    end
  endtask

  // returns at the first negedge of window cycle 1; j counts window cycles after that
  task automatic run_window(input logic [7:0] k, input int mode, input int rd_at);
    int n;
    n = 0;
    t3a = k;
    t4b = k;
    for (int j = 1; j <= 60; j++) begin
      @(negedge clk);
      if (j == 2) begin
        t3a = 0;
        t4b = 0;
      end
      if (mode == 1) begin
        if (j == 3 || j == 20) t3a = 8'h04;
        if (j == 5 || j == 22) t3a = 8'h00;
        if (j == 10) t4b = 8'h80;
        if (j == 12) t4b = 8'h00;
      end
      if (mode == 2) t4a = (j >= 50 && j < 52) ? 8'hff : 8'h00;
      if (mode == 3) scin = (j >= 10 && j < 13) || (j >= 53 && j < 56);
      if (rd_at != 0) rd = j >= rd_at && j < rd_at + 4;
    end
    while (busy && n < 20) begin
      @(negedge clk);
      n++;
    end
    n_chk++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL event_end_busy got %b want 0", busy);
    end
  endtask

  task automatic pop1(output logic [17:0] r);
    @(negedge clk) rd = 1;
    repeat (6) @(negedge clk);
    rd = 0;
    repeat (3) @(negedge clk);
    r = {x, y, lay, val};
  endtask

  task automatic pop2(output logic [17:0] r);
    @(negedge clk) rd2 = 1;
    repeat (6) @(negedge clk);
    rd2 = 0;
    repeat (3) @(negedge clk);
    r = {x2, y2, lay2, val2};
  endtask

  task automatic ev2(input int i);
    int n;
    n = 0;
    @(negedge clk) scin2 = 1;
    repeat (3) @(negedge clk);
    scin2 = 0;
    t3a = 8'(1 << i);
    repeat (2) @(negedge clk);
    t3a = 0;
    repeat (3) @(negedge clk);
    n_chk++;
    if (busy2 !== 1'b1) begin
      n_fail++;
      $display("FAIL ev2_busy[%0d] got %b want 1", i, busy2);
    end
    while (busy2 && n < 30) begin
      @(negedge clk);
      n++;
    end
    n_chk++;
    if (busy2 !== 1'b0) begin
      n_fail++;
      $display("FAIL ev2_idle[%0d] got %b want 0", i, busy2);
    end
  endtask

  task automatic test_reset();
    logic [17:0] r;
    repeat (3) @(negedge clk);
    n_chk++;
    if ({x, y, lay, val, emp, busy, drop} !== {8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00}) begin
      n_fail++;
      $display("FAIL reset_u1 got %h want %h", {x, y, lay, val, emp, busy, drop}, {8'h00, 8'h00, 4'b0010, 8'h00});
    end
    n_chk++;
    if ({emp2, busy2, drop2} !== 4'b1000) begin
      n_fail++;
      $display("FAIL reset_u2 got %b want 1000", {emp2, busy2, drop2});
    end
    rst = 0;
    repeat (2) begin
      start_event();
      run_window(8'h11, 0, 0);
    end
    pop1(r);
    n_chk++;
    if (r !== {8'h11, 8'h00, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL pre_reset_pop got %h want %h", r, {8'h11, 8'h00, 2'b01});
    end
    start_event();
    repeat (20) @(negedge clk);
    rst = 1;
    @(negedge clk);
    n_chk++;
    if ({x, y, lay, val, emp, busy, drop} !== {8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00}) begin
      n_fail++;
      $display("FAIL reset_mid_window got %h want %h", {x, y, lay, val, emp, busy, drop}, {8'h00, 8'h00, 4'b0010, 8'h00});
    end
    repeat (2) @(negedge clk);
    rst = 0;
    pop1(r);
    n_chk++;
    if ({r, emp} !== {8'h00, 8'h00, 1'b0, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL reset_then_pop got %h want %h", {r, emp}, {8'h00, 8'h00, 3'b001});
    end
  endtask

  task automatic test_basic();
    logic [17:0] r;
    start_event();
    run_window(8'h00, 1, 0);
    pop1(r);
    n_chk++;
    if (r !== {8'h04, 8'h00, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL basic_word_a got %h want %h", r, {8'h04, 8'h00, 2'b01});
    end
    pop1(r);
    n_chk++;
    if (r !== {8'h00, 8'h80, 1'b1, 1'b1}) begin
      n_fail++;
      $display("FAIL basic_word_b got %h want %h", r, {8'h00, 8'h80, 2'b11});
    end
    n_chk++;
    if (emp !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_empty got %b want 1", emp);
    end
    pop1(r);
    n_chk++;
    if (r !== {8'h00, 8'h80, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL basic_pop_empty got %h want %h", r, {8'h00, 8'h80, 2'b10});
    end
  endtask

  task automatic test_window_bounds();
    logic [17:0] r;
    @(negedge clk) t3b = 8'h02;
    repeat (2) @(negedge clk);
    t3b = 0;
    repeat (2) @(negedge clk);
    start_event();
    run_window(8'h00, 2, 0);
    pop1(r);
    n_chk++;
    if (r !== {8'h00, 8'h00, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL bounds_word_a got %h want %h", r, {8'h00, 8'h00, 2'b01});
    end
    pop1(r);
    n_chk++;
    if ({r, emp} !== {8'h00, 8'h00, 1'b1, 1'b1, 1'b1}) begin
      n_fail++;
      $display("FAIL bounds_word_b got %h want %h", {r, emp}, {8'h00, 8'h00, 3'b111});
    end
  endtask

  task automatic test_ignore_trig();
    logic [17:0] r;
    start_event();
    run_window(8'h00, 3, 0);
    repeat (5) @(negedge clk);
    n_chk++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL holdoff_trig_ignored got %b want 0", busy);
    end
    pop1(r);
    pop1(r);
    n_chk++;
    if ({r, emp} !== {8'h00, 8'h00, 1'b1, 1'b1, 1'b1}) begin
      n_fail++;
      $display("FAIL ignore_two_words got %h want %h", {r, emp}, {8'h00, 8'h00, 3'b111});
    end
    start_event();
    run_window(8'h00, 0, 0);
    pop1(r);
    pop1(r);
    n_chk++;
    if ({r, emp} !== {8'h00, 8'h00, 1'b1, 1'b1, 1'b1}) begin
      n_fail++;
      $display("FAIL after_holdoff_event got %h want %h", {r, emp}, {8'h00, 8'h00, 3'b111});
    end
  endtask

  task automatic test_fifo_full();
    logic [17:0] r;
    logic [17:0] exp [4];
    exp[0] = {8'h01, 8'h00, 2'b01};
    exp[1] = {8'h00, 8'h00, 2'b11};
    exp[2] = {8'h02, 8'h00, 2'b01};
    exp[3] = {8'h00, 8'h00, 2'b11};
    for (int i = 0; i < 3; i++) ev2(i);
    n_chk++;
    if ({drop2, emp2} !== 3'b010) begin
      n_fail++;
      $display("FAIL full_one_drop got %b want 010", {drop2, emp2});
    end
    for (int i = 3; i < 7; i++) ev2(i);
    n_chk++;
    if (drop2 !== 2'd3) begin
      n_fail++;
      $display("FAIL drop_saturate got %0d want 3", drop2);
    end
    for (int i = 0; i < 4; i++) begin
      pop2(r);
      n_chk++;
      if (r !== exp[i]) begin
        n_fail++;
        $display("FAIL full_pop[%0d] got %h want %h", i, r, exp[i]);
      end
    end
    n_chk++;
    if (emp2 !== 1'b1) begin
      n_fail++;
      $display("FAIL full_drained got %b want 1", emp2);
    end
  endtask

  task automatic test_wrap_concurrent();
    logic [17:0] r, e;
    int ev;
    for (int k = 1; k <= 7; k++) begin
      start_event();
      run_window(8'(k), 0, 0);
    end
    start_event();
    run_window(8'd8, 0, 47);
    n_chk++;
    if ({x, y, lay, val, emp} !== {8'h01, 8'h00, 1'b0, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL pop_during_push got %h want %h", {x, y, lay, val, emp}, {8'h01, 8'h00, 3'b010});
    end
    for (int m = 0; m < 15; m++) begin
      ev = m == 0 ? 1 : 2 + (m - 1) / 2;
      e = (m != 0 && (m - 1) % 2 == 0) ? {8'(ev), 8'h00, 2'b01} : {8'h00, 8'(ev), 2'b11};
      pop1(r);
      n_chk++;
      if (r !== e) begin
        n_fail++;
        $display("FAIL wrap_pop[%0d] got %h want %h", m, r, e);
      end
`ifdef EVENT_TAG_EN
      n_chk++;
      if (tag !== 4'(ev + 3)) begin
        n_fail++;
        $display("FAIL wrap_tag[%0d] got %0d want %0d", m, tag, 4'(ev + 3));
      end
`endif
    end
    n_chk++;
    if ({emp, drop} !== {1'b1, 8'h00}) begin
      n_fail++;
      $display("FAIL wrap_end got %h want %h", {emp, drop}, {1'b1, 8'h00});
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_window_bounds();
    test_ignore_trig();
    test_fifo_full();
    test_wrap_concurrent();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
